// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if: host command handshake into the run/step/halt sequencer
interface core_run_ctrl_if #(parameter int CNT_W = 32);
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [CNT_W-1:0] cmd_count;
  modport master (output cmd_valid, cmd_op, cmd_count, input cmd_ready);
  modport slave (input cmd_valid, cmd_op, cmd_count, output cmd_ready);
endinterface

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/step/halt sequencer gating reset and commit of a single-cycle core
module core_run_ctrl #(
  parameter int RST_CYCLES = 3,
  parameter int CNT_W = 32,
  parameter int NOP_LIMIT = 2,
  parameter int MAX_RETIRE = 1000,
  parameter bit AUTO_RUN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  core_run_ctrl_if.slave   cmd,
  input  logic             bp_en,
  input  logic [31:0]      bp_pc,
  input  logic [31:0]      core_pc,
  input  logic [31:0]      core_instr,
  output logic             core_rst,
  output logic             core_en,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       halt_cause,
  output logic             done
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL = 32'h0000_006F;
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int NW = $clog2(NOP_LIMIT + 1);
  typedef enum logic [2:0] {S_RST, S_HALT, S_RUN, S_STEP, S_DONE} st_t;
  st_t st;
  logic [RW-1:0] rst_cnt;
  logic [NW-1:0] nop_run, nop_nx;
  logic [CNT_W-1:0] step_left, ret_nx;
  logic bp_skip, active, bp_hit, acc, rstrt, hlt, go_run, go_step, at_end, step_done, tmo;
  assign state = st;
  assign active = st == S_RUN || st == S_STEP;
  assign bp_hit = bp_en && core_pc == bp_pc && !bp_skip;
  assign core_en = active && !bp_hit;
  assign core_rst = st == S_RST;
  assign cmd.cmd_ready = st != S_RST;
  assign acc = cmd.cmd_valid && cmd.cmd_ready;
  assign rstrt = acc && cmd.cmd_op == 2'b11;
  assign hlt = acc && cmd.cmd_op == 2'b10 && active;
  assign go_run = acc && cmd.cmd_op == 2'b00 && st == S_HALT;
  assign go_step = acc && cmd.cmd_op == 2'b01 && st == S_HALT;
  assign nop_nx = core_instr == NOP ? nop_run + NW'(1) : '0;
  assign ret_nx = &retired ? retired : retired + CNT_W'(1);
  assign at_end = core_en && (core_instr == JAL || nop_nx == NW'(NOP_LIMIT));
  assign step_done = core_en && st == S_STEP && step_left == CNT_W'(1);
  // fires only on the retire that lands exactly on the limit, so a later RUN continues
  assign tmo = core_en && st == S_RUN && MAX_RETIRE != 0 && retired != ret_nx &&
               ret_nx == CNT_W'(MAX_RETIRE);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= S_RST;
      rst_cnt <= '0;
      retired <= '0;
      halt_cause <= 3'd0;
      done <= 1'b0;
      nop_run <= '0;
      bp_skip <= 1'b0;
      step_left <= '0;
    end else begin
      done <= 1'b0;
      if (core_en) begin
        retired <= ret_nx;
        bp_skip <= 1'b0;
        nop_run <= nop_nx;
        step_left <= step_left - CNT_W'(1);
      end
      if (rstrt) begin
        st <= S_RST;
        rst_cnt <= '0;
        retired <= '0;
        halt_cause <= 3'd0;
        nop_run <= '0;
        bp_skip <= 1'b0;
      end else if (st == S_RST) begin
        rst_cnt <= rst_cnt + RW'(1);
        if (rst_cnt == RW'(RST_CYCLES - 1)) st <= AUTO_RUN ? S_RUN : S_HALT;
      end else if (at_end) begin
        st <= S_DONE;
        halt_cause <= 3'd4;
        done <= 1'b1;
      end else if (step_done) begin
        st <= S_HALT;
        halt_cause <= 3'd2;
      end else if (tmo) begin
        st <= S_HALT;
        halt_cause <= 3'd5;
      end else if (active && bp_hit) begin
        st <= S_HALT;
        halt_cause <= 3'd3;
      end else if (hlt) begin
        st <= S_HALT;
        halt_cause <= 3'd1;
      end else if (go_run || go_step) begin
        st <= go_run ? S_RUN : S_STEP;
        halt_cause <= 3'd0;
        // resuming from a breakpoint lets the instruction at bp_pc commit once
        bp_skip <= halt_cause == 3'd3;
        step_left <= cmd.cmd_count == '0 ? CNT_W'(1) : cmd.cmd_count;
      end
    end
  end
endmodule
